// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: drives the PLL reset, debounces lock with a timeout and bounded retries,
// and releases downstream domain resets in staggered order once lock is stable.
module pll_reset_sequencer #(
    parameter int unsigned RST_CYCLES     = 50,
    parameter int unsigned LOCK_TIMEOUT   = 50000,
    parameter int unsigned STABLE_CYCLES  = 1000,
    parameter int unsigned STAGGER_CYCLES = 16,
    parameter int unsigned NUM_DOMAINS    = 3,
    parameter int unsigned MAX_RETRY      = 4
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    input  logic                   restart,
    input  logic                   pll_locked,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   ready,
    output logic                   fail,
    output logic [2:0]             retry_cnt,
    output logic [7:0]             lock_loss_cnt
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned LastRel = (NUM_DOMAINS - 1) * STAGGER_CYCLES;
    localparam int unsigned CntMax  = max2(max2(RST_CYCLES, LOCK_TIMEOUT),
                                           max2(STABLE_CYCLES, LastRel + 1));
    localparam int unsigned CntW    = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StReset,
        StWaitLock,
        StStable,
        StRelease,
        StRun,
        StFail
    } state_e;

    state_e                 state_q;
    logic [CntW-1:0]        cnt_q;
    logic                   lock_meta_q;
    logic                   lock_s_q;
    logic                   pll_rst_q;
    logic [NUM_DOMAINS-1:0] domain_rst_q;
    logic                   ready_q;
    logic                   fail_q;
    logic [2:0]             retry_cnt_q;
    logic [7:0]             lock_loss_cnt_q;

    int unsigned            cnt_next;
    logic [NUM_DOMAINS-1:0] rel_mask;
    logic [2:0]             retry_inc;

    // rel_mask marks the domains whose release slot has been reached on the coming cycle.
    always_comb begin
        cnt_next  = 32'(cnt_q) + 32'd1;
        retry_inc = retry_cnt_q + 3'd1;
        rel_mask  = '0;
        for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
            rel_mask[i] = (cnt_next >= i * STAGGER_CYCLES);
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q         <= StReset;
            cnt_q           <= '0;
            lock_meta_q     <= 1'b0;
            lock_s_q        <= 1'b0;
            pll_rst_q       <= 1'b1;
            domain_rst_q    <= '1;
            ready_q         <= 1'b0;
            fail_q          <= 1'b0;
            retry_cnt_q     <= '0;
            lock_loss_cnt_q <= '0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_s_q    <= lock_meta_q;
            cnt_q       <= cnt_q + 1'b1;
            if (restart) begin
                state_q      <= StReset;
                cnt_q        <= '0;
                pll_rst_q    <= 1'b1;
                domain_rst_q <= '1;
                ready_q      <= 1'b0;
                fail_q       <= 1'b0;
                retry_cnt_q  <= '0;
            end else begin
                unique case (state_q)
                    StReset: begin
                        if (32'(cnt_q) == RST_CYCLES - 1) begin
                            state_q   <= StWaitLock;
                            cnt_q     <= '0;
                            pll_rst_q <= 1'b0;
                        end
                    end
                    StWaitLock: begin
                        if (lock_s_q) begin
                            state_q <= StStable;
                            cnt_q   <= '0;
                        end else if (32'(cnt_q) == LOCK_TIMEOUT - 1) begin
                            cnt_q       <= '0;
                            retry_cnt_q <= retry_inc;
                            pll_rst_q   <= 1'b1;
                            if (retry_inc == 3'(MAX_RETRY)) begin
                                state_q <= StFail;
                                fail_q  <= 1'b1;
                            end else begin
                                state_q <= StReset;
                            end
                        end
                    end
                    StStable: begin
                        if (!lock_s_q) begin
                            state_q <= StWaitLock;
                            cnt_q   <= '0;
                        end else if (32'(cnt_q) == STABLE_CYCLES - 1) begin
                            cnt_q <= '0;
                            if (LastRel == 0) begin
                                state_q      <= StRun;
                                domain_rst_q <= '0;
                                ready_q      <= 1'b1;
                                retry_cnt_q  <= '0;
                            end else begin
                                state_q         <= StRelease;
                                domain_rst_q[0] <= 1'b0;
                            end
                        end
                    end
                    StRelease, StRun: begin
                        if (!lock_s_q) begin
                            state_q      <= StReset;
                            cnt_q        <= '0;
                            pll_rst_q    <= 1'b1;
                            domain_rst_q <= '1;
                            ready_q      <= 1'b0;
                            retry_cnt_q  <= '0;
                            if (lock_loss_cnt_q != 8'hFF) begin
                                lock_loss_cnt_q <= lock_loss_cnt_q + 8'd1;
                            end
                        end else if (state_q == StRelease) begin
                            domain_rst_q <= ~rel_mask;
                            if (cnt_next == LastRel) begin
                                state_q     <= StRun;
                                cnt_q       <= '0;
                                ready_q     <= 1'b1;
                                retry_cnt_q <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q;
                        end
                    end
                    StFail: begin
                        cnt_q <= cnt_q;
                    end
                    default: begin
                        state_q      <= StReset;
                        cnt_q        <= '0;
                        pll_rst_q    <= 1'b1;
                        domain_rst_q <= '1;
                        ready_q      <= 1'b0;
                        fail_q       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pll_rst       = pll_rst_q;
    assign domain_rst    = domain_rst_q;
    assign ready         = ready_q;
    assign fail          = fail_q;
    assign retry_cnt     = retry_cnt_q;
    assign lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: phase-level reference model checked every cycle, plus directed
// literal checkpoints for bring-up, debounce, lock loss, timeout/fail, saturation and reset.
module tb_pll_reset_sequencer;

    localparam int RST   = 4;
    localparam int TO    = 20;
    localparam int STB   = 8;
    localparam int STG   = 2;
    localparam int ND    = 3;
    localparam int MAXR  = 2;
    localparam int LASTR = (ND - 1) * STG;

    localparam int P_RESET = 0, P_WAIT = 1, P_STABLE = 2, P_RELEASE = 3, P_RUN = 4, P_FAIL = 5;

    logic          refclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          restart = 1'b0;
    logic          pll_locked = 1'b0;
    logic          pll_rst;
    logic [ND-1:0] domain_rst;
    logic          ready;
    logic          fail;
    logic [2:0]    retry_cnt;
    logic [7:0]    lock_loss_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: phase, cycles elapsed in phase, counters, two-stage lock history.
    int phase = P_RESET, el = 0, retries = 0, losses = 0, cyc = 0;
    bit h1 = 0, h2 = 0, lk = 0, model_valid = 0;

    pll_reset_sequencer #(
        .RST_CYCLES    (RST),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (STB),
        .STAGGER_CYCLES(STG),
        .NUM_DOMAINS   (ND),
        .MAX_RETRY     (MAXR)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .restart      (restart),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .domain_rst   (domain_rst),
        .ready        (ready),
        .fail         (fail),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    function automatic logic [16:0] model_outputs();
        logic [2:0] dom;
        dom = 3'b111;
        if (phase == P_RUN) dom = 3'b000;
        else if (phase == P_RELEASE)
            for (int i = 0; i < ND; i++) dom[i] = (el < i * STG);
        return {(phase == P_RESET || phase == P_FAIL), dom, (phase == P_RUN), (phase == P_FAIL),
                3'(retries), 8'(losses)};
    endfunction

    task automatic model_lose_lock();
        phase   = P_RESET;
        el      = 0;
        retries = 0;
        if (losses < 255) losses++;
    endtask

    initial begin
        forever begin
            @(posedge refclk);
            cyc++;
            if (!rst_n) begin
                phase = P_RESET; el = 0; retries = 0; losses = 0;
                h1 = 0; h2 = 0; model_valid = 1;
            end else begin
                lk = h2; h2 = h1; h1 = pll_locked;
                if (restart) begin
                    phase = P_RESET; el = 0; retries = 0;
                end else begin
                    case (phase)
                        P_RESET: begin
                            el++;
                            if (el == RST) begin phase = P_WAIT; el = 0; end
                        end
                        P_WAIT: begin
                            if (lk) begin phase = P_STABLE; el = 0; end
                            else begin
                                el++;
                                if (el == TO) begin
                                    retries++;
                                    phase = (retries == MAXR) ? P_FAIL : P_RESET;
                                    el = 0;
                                end
                            end
                        end
                        P_STABLE: begin
                            if (!lk) begin phase = P_WAIT; el = 0; end
                            else begin
                                el++;
                                if (el == STB) begin
                                    el = 0;
                                    phase = (LASTR == 0) ? P_RUN : P_RELEASE;
                                    if (phase == P_RUN) retries = 0;
                                end
                            end
                        end
                        P_RELEASE: begin
                            if (!lk) model_lose_lock();
                            else begin
                                el++;
                                if (el == LASTR) begin phase = P_RUN; retries = 0; end
                            end
                        end
                        P_RUN: if (!lk) model_lose_lock();
                        default: ;
                    endcase
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge refclk);
            if (model_valid)
                check($sformatf("outputs@cycle%0d", cyc),
                      32'({pll_rst, domain_rst, ready, fail, retry_cnt, lock_loss_cnt}),
                      32'(model_outputs()));
        end
    end

    task automatic wait_release();
        bit found;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (domain_rst[0] == 1'b0) found = 1;
            else tick(1);
        end
        check("wait_release", 32'(found), 32'd1);
    endtask

    initial begin
        // Reset and nominal bring-up
        tick(3);
        rst_n = 1'b1;
        check("rst_pll_rst", 32'(pll_rst), 32'd1);
        check("rst_domain_rst", 32'(domain_rst), 32'h7);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_retry", 32'(retry_cnt), 32'd0);
        check("rst_loss", 32'(lock_loss_cnt), 32'd0);
        tick(4);
        check("pll_rst_low_after_4", 32'(pll_rst), 32'd0);
        tick(6);
        pll_locked = 1'b1;
        tick(11);
        check("release_bit0", 32'(domain_rst), 32'h6);
        tick(3);
        check("release_bit1", 32'(domain_rst), 32'h4);
        check("ready_before_last", 32'(ready), 32'd0);
        tick(1);
        check("run_domain_rst", 32'(domain_rst), 32'h0);
        check("run_ready", 32'(ready), 32'd1);

        // Lock loss in RUN, then re-lock
        tick(5);
        pll_locked = 1'b0;
        tick(2);
        check("loss_not_yet_seen", 32'(ready), 32'd1);
        tick(1);
        check("loss_domain_rst", 32'(domain_rst), 32'h7);
        check("loss_ready", 32'(ready), 32'd0);
        check("loss_cnt_1", 32'(lock_loss_cnt), 32'd1);
        tick(4);
        check("loss_pll_rst_4", 32'(pll_rst), 32'd0);
        pll_locked = 1'b1;
        tick(15);
        check("relock_ready", 32'(ready), 32'd1);

        // Restart from RUN, then a one-cycle lock glitch in STABLE
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check("restart_ready", 32'(ready), 32'd0);
        check("restart_loss_kept", 32'(lock_loss_cnt), 32'd1);
        tick(7);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(10);
        check("debounce_hold", 32'(domain_rst), 32'h7);
        tick(1);
        check("debounce_release", 32'(domain_rst), 32'h6);
        tick(4);
        check("debounce_run", 32'(ready), 32'd1);

        // Restart in the same cycle the lock loss is seen
        pll_locked = 1'b0;
        tick(2);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check("prio_loss_cnt", 32'(lock_loss_cnt), 32'd1);
        check("prio_domain_rst", 32'(domain_rst), 32'h7);

        // Timeouts into FAIL
        tick(23);
        check("to1_before_retry", 32'(retry_cnt), 32'd0);
        tick(1);
        check("to1_retry", 32'(retry_cnt), 32'd1);
        check("to1_pll_rst", 32'(pll_rst), 32'd1);
        tick(23);
        check("to2_not_fail", 32'(fail), 32'd0);
        tick(1);
        check("to2_fail", 32'(fail), 32'd1);
        check("to2_retry", 32'(retry_cnt), 32'd2);
        tick(30);
        check("fail_held", 32'(fail), 32'd1);
        check("fail_pll_rst", 32'(pll_rst), 32'd1);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check("fail_restart_fail", 32'(fail), 32'd0);
        check("fail_restart_retry", 32'(retry_cnt), 32'd0);

        // Saturate the lock-loss counter via repeated losses during RELEASE
        pll_locked = 1'b1;
        for (int k = 0; k < 258; k++) begin
            wait_release();
            pll_locked = 1'b0;
            tick(1);
            pll_locked = 1'b1;
            tick(2);
        end
        check("loss_saturated", 32'(lock_loss_cnt), 32'd255);

        // rst_n in the middle of RELEASE
        wait_release();
        rst_n = 1'b0;
        tick(1);
        check("midrst_domain_rst", 32'(domain_rst), 32'h7);
        check("midrst_loss", 32'(lock_loss_cnt), 32'd0);
        check("midrst_retry", 32'(retry_cnt), 32'd0);
        check("midrst_pll_rst", 32'(pll_rst), 32'd1);
        rst_n = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controls the system PLL (50 MHz ref in; 100/50/40 MHz out) from the reference-clock domain.
- Drives the PLL reset, debounces its asynchronous `locked` flag and applies a lock timeout with bounded retries.
- Releases per-output-domain resets in staggered order once lock is stable.
- On loss of lock, re-asserts all domain resets and restarts the PLL.

Parameters:
- RST_CYCLES, 50: refclk cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT, 50000: refclk cycles allowed in WAIT_LOCK before retry (>=1).
- STABLE_CYCLES, 1000: consecutive synchronized-lock-high cycles required before release (>=1).
- STAGGER_CYCLES, 16: refclk cycles between successive domain reset releases (>=1).
- NUM_DOMAINS, 3: number of downstream clock domains (bit i = PLL outclk_i).
- MAX_RETRY, 4: failed lock attempts before FAIL (>=1).

Ports:
- refclk  in  1  50 MHz reference clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- restart  in  1  single-cycle software restart request.
- pll_locked  in  1  PLL lock flag, asynchronous to refclk.
- pll_rst  out  1  reset to PLL, active high.
- domain_rst  out  NUM_DOMAINS  per-domain reset, active high; each consumer resynchronizes it.
- ready  out  1  high in RUN only.
- fail  out  1  high in FAIL only.
- retry_cnt  out  3  failed attempts in the current sequence.
- lock_loss_cnt  out  8  lock losses after reaching RELEASE/RUN; saturates at 255.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=RESET, counters cleared.
  - pll_rst=1, domain_rst=all 1s, ready=0, fail=0, retry_cnt=0, lock_loss_cnt=0.
  - Sync flops cleared.
- Lock synchronization:
  - pll_locked passes through 2 flops to give lock_s.
  - An edge on pll_locked is visible to the FSM 2 cycles later.
- All outputs are registered.
- FSM states: RESET, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL. A single cycle counter cnt is cleared on every state entry.
- RESET:
  - pll_rst=1, domain_rst=all 1s.
  - pll_rst is high for exactly RST_CYCLES cycles, then -> WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst=0.
  - lock_s=1 -> STABLE.
  - Otherwise, when cnt reaches LOCK_TIMEOUT-1, retry_cnt increments; then -> FAIL if the new retry_cnt==MAX_RETRY, else -> RESET.
- STABLE:
  - lock_s=0 -> WAIT_LOCK; timeout restarts and retry_cnt is unchanged.
  - After STABLE_CYCLES consecutive lock_s=1 cycles -> RELEASE.
- RELEASE:
  - domain_rst[i] deasserts at cycle i*STAGGER_CYCLES after entry, so bit 0 clears on the first RELEASE cycle.
  - Released bits stay low.
  - When bit NUM_DOMAINS-1 clears, go to RUN. ready=1 in the same cycle as the last release; retry_cnt clears.
- RUN:
  - ready=1, domain_rst=0.
- Lock loss (lock_s=0 in RELEASE or RUN):
  - Next cycle: domain_rst=all 1s, ready=0.
  - lock_loss_cnt increments, saturating at 255.
  - retry_cnt clears; -> RESET.
- FAIL:
  - pll_rst=1, domain_rst=all 1s, fail=1.
  - Held until restart or rst_n.
- restart=1 in any state:
  - -> RESET, retry_cnt=0, fail=0, domain_rst=all 1s.
  - lock_loss_cnt is not incremented and not cleared.
  - restart takes priority over lock loss, timeout and stable completion in the same cycle.
- rst_n has priority over everything, including restart.
- pll_locked glitches shorter than one refclk cycle may be missed. Any lock_s=0 sample in STABLE aborts the stable count.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, STAGGER_CYCLES=2, NUM_DOMAINS=3, MAX_RETRY=2):
1. Nominal bring-up:
   - Stimulus: release rst_n at cycle 0; pll_locked=1 from cycle 10.
   - Response: pll_rst high for cycles 1-4; lock_s seen at cycle 12; RELEASE entered after 8 stable cycles.
   - domain_rst bits clear at +0, +2 and +4 cycles; ready=1 with the last release; retry_cnt=0.
2. Timeout and fail:
   - Stimulus: pll_locked held 0.
   - Response: two RESET(4)+WAIT_LOCK(20) attempts; retry_cnt goes 1 then 2.
   - fail=1 with pll_rst=1 held indefinitely; a restart pulse returns to RESET with fail=0 and retry_cnt=0.
3. Debounce:
   - Stimulus: in STABLE, drop pll_locked for 1 cycle after 5 stable cycles.
   - Response: FSM returns to WAIT_LOCK; domain_rst stays all 1s; a full 8-cycle stable window is needed again.
4. Lock loss in RUN:
   - Stimulus: drop pll_locked.
   - Response: 3 cycles later domain_rst=3'b111 and ready=0; lock_loss_cnt 0->1; pll_rst=1 for 4 cycles; re-lock gives RUN again.
5. Saturation and priority:
   - Stimulus: force 256 lock losses; separately, assert restart in the same cycle as a lock loss.
   - Response: lock_loss_cnt stays at 255; the restart cycle does not increment the counter.
6. Reset mid-sequence:
   - Stimulus: rst_n=0 during RELEASE after bit 0 has cleared.
   - Response: next edge gives domain_rst=3'b111, all counters 0, state RESET.
